// File: rtl/graphics_pkg.sv
// rtl/graphics_pkg.sv - shared VGA timing constants, colour types and palette defaults
package graphics_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int DEF_COLOR_BITS = 2;

  typedef struct packed {
    logic [DEF_COLOR_BITS-1:0] r;
    logic [DEF_COLOR_BITS-1:0] g;
    logic [DEF_COLOR_BITS-1:0] b;
  } rgb_t;

  // Raster signals carried down the delay line; syncs are active-high here.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } raster_t;

  localparam rgb_t WHITE = '1;
  localparam rgb_t BLACK = '0;

  function automatic rgb_t pack_rgb(input logic [DEF_COLOR_BITS-1:0] r,
                                    input logic [DEF_COLOR_BITS-1:0] g,
                                    input logic [DEF_COLOR_BITS-1:0] b);
    rgb_t c;
    c.r = r;
    c.g = g;
    c.b = b;
    return c;
  endfunction

endpackage

// File: rtl/graphics_layer_mixer_vga_timing.sv
// rtl/graphics_layer_mixer_vga_timing.sv - raster counters, display enable, raw syncs and frame start
module vga_timing
  import graphics_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hpos_o,
  output logic [9:0] vpos_o,
  output logic       display_on_o,
  output logic       hsync_raw_o,
  output logic       vsync_raw_o,
  output logic       frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
      $error("vga_timing: raster totals exceed the 10-bit counters");
    end
  endgenerate

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;

  always_comb begin
    hpos_d = hpos_q + 10'd1;
    vpos_d = vpos_q;
    if (hpos_q == 10'(H_TOTAL - 1)) begin
      hpos_d = '0;
      vpos_d = (vpos_q == 10'(V_TOTAL - 1)) ? 10'd0 : vpos_q + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hpos_q <= '0;
      vpos_q <= '0;
    end else begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
    end
  end

  assign hpos_o        = hpos_q;
  assign vpos_o        = vpos_q;
  assign display_on_o  = (32'(hpos_q) < H_ACTIVE) && (32'(vpos_q) < V_ACTIVE);
  assign hsync_raw_o   = (32'(hpos_q) >= H_ACTIVE + H_FP) && (32'(hpos_q) < H_ACTIVE + H_FP + H_SYNC);
  assign vsync_raw_o   = (32'(vpos_q) >= V_ACTIVE + V_FP) && (32'(vpos_q) < V_ACTIVE + V_FP + V_SYNC);
  assign frame_start_o = (hpos_q == 10'd0) && (vpos_q == 10'd0);

endmodule

// File: rtl/graphics_layer_mixer.sv
// rtl/graphics_layer_mixer.sv - priority layer resolve into a run-time palette with latency-matched syncs
module graphics_layer_mixer
  import graphics_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int SYNC_NEG   = 1,
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_BITS = DEF_COLOR_BITS,
  parameter int LAYER_LAT  = 0,
  parameter int CONV       = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_LAYERS-1:0]                i_layer_hit,
  input  logic                                 i_pal_we,
  input  logic [$clog2(NUM_LAYERS+1)-1:0]      i_pal_addr,
  input  logic [3*COLOR_BITS-1:0]              i_pal_data,
  output logic [9:CONV]                        o_hpos,
  output logic [9:CONV]                        o_vpos,
  output logic                                 o_frame_start,
  output logic                                 o_hsync,
  output logic                                 o_vsync,
  output logic [COLOR_BITS-1:0]                o_red,
  output logic [COLOR_BITS-1:0]                o_green,
  output logic [COLOR_BITS-1:0]                o_blue
);

  localparam int AW = $clog2(NUM_LAYERS + 1);
  localparam int CW = 3 * COLOR_BITS;

  logic [9:0] hpos, vpos;
  raster_t    raw, dly;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk          (clk),
    .reset        (reset),
    .hpos_o       (hpos),
    .vpos_o       (vpos),
    .display_on_o (raw.de),
    .hsync_raw_o  (raw.hs),
    .vsync_raw_o  (raw.vs),
    .frame_start_o(o_frame_start)
  );

  assign o_hpos = hpos[9:CONV];
  assign o_vpos = vpos[9:CONV];

  // Raster signals follow the renderers' pipeline so they meet i_layer_hit in step.
  generate
    if (LAYER_LAT == 0) begin : g_no_dly
      assign dly = raw;
    end else begin : g_dly
      raster_t pipe_q [LAYER_LAT];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < LAYER_LAT; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= raw;
          for (int i = 1; i < LAYER_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign dly = pipe_q[LAYER_LAT-1];
    end
  endgenerate

  logic [AW-1:0] win_idx;
  logic [CW-1:0] pal_q [NUM_LAYERS+1];
  logic [CW-1:0] color_d, color_q;
  logic          hs_q, vs_q;

  always_comb begin
    win_idx = AW'(NUM_LAYERS);
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (i_layer_hit[k]) win_idx = AW'(k);
    end
  end

  assign color_d = dly.de ? pal_q[win_idx] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      color_q <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      color_q <= color_d;
      hs_q    <= dly.hs;
      vs_q    <= dly.vs;
    end
  end

  // Layers default to white, background to black; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= NUM_LAYERS; k++) pal_q[k] <= (k == NUM_LAYERS) ? '0 : '1;
    end else if (i_pal_we && (int'(i_pal_addr) <= NUM_LAYERS)) begin
      pal_q[i_pal_addr] <= i_pal_data;
    end
  end

  assign o_hsync = (SYNC_NEG != 0) ? ~hs_q : hs_q;
  assign o_vsync = (SYNC_NEG != 0) ? ~vs_q : vs_q;
  assign o_red   = color_q[CW-1 -: COLOR_BITS];
  assign o_green = color_q[2*COLOR_BITS-1 -: COLOR_BITS];
  assign o_blue  = color_q[COLOR_BITS-1:0];

endmodule

// File: tb/tb_graphics_layer_mixer.sv
// tb/tb_graphics_layer_mixer.sv - randomized scoreboard bench for graphics_layer_mixer
module tb_graphics_layer_mixer;
  import graphics_pkg::*;

  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 8,  VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int NL = 4;
  localparam int LAT = 2;
  localparam int SNEG = 1;
  localparam int N_CYC = 1300;

  logic          clk = 1'b0;
  logic          reset;
  logic [NL-1:0] hit;
  logic          pal_we;
  logic [2:0]    pal_addr;
  logic [5:0]    pal_data;
  logic [9:0]    o_hpos, o_vpos;
  logic          o_frame_start, o_hsync, o_vsync;
  logic [1:0]    o_red, o_green, o_blue;

  graphics_layer_mixer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_NEG(SNEG), .NUM_LAYERS(NL), .COLOR_BITS(2), .LAYER_LAT(LAT), .CONV(0)
  ) dut (
    .clk(clk), .reset(reset), .i_layer_hit(hit),
    .i_pal_we(pal_we), .i_pal_addr(pal_addr), .i_pal_data(pal_data),
    .o_hpos(o_hpos), .o_vpos(o_vpos), .o_frame_start(o_frame_start),
    .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [5:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t    sb[$];
  raster_t hist[$];
  logic [5:0] pal_m [0:NL];
  int mh, mv, cyc, n_chk, n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic model_reset();
    mh = 0;
    mv = 0;
    hist.delete();
    for (int i = 0; i < LAT; i++) hist.push_back('{hs: 1'b0, vs: 1'b0, de: 1'b0});
    for (int k = 0; k < NL; k++) pal_m[k] = WHITE;
    pal_m[NL] = BLACK;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("rgb", {26'd0, o_red, o_green, o_blue}, {26'd0, e.rgb});
        chk("hsync", {31'd0, o_hsync}, {31'd0, (SNEG != 0) ? ~e.hs : e.hs});
        chk("vsync", {31'd0, o_vsync}, {31'd0, (SNEG != 0) ? ~e.vs : e.vs});
      end
    end
  end

  initial begin
    bit      rst_now, did_rst;
    int      frames, last_fs, idx;
    raster_t cur, d;
    exp_t    e;
    n_chk = 0; n_pass = 0; cyc = 0;
    did_rst = 0; frames = 0; last_fs = -1;
    reset = 1'b1; hit = '0; pal_we = 1'b0; pal_addr = '0; pal_data = '0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    for (int c = 0; c < N_CYC; c++) begin
      chk("hpos", {22'd0, o_hpos}, 32'(mh));
      chk("vpos", {22'd0, o_vpos}, 32'(mv));
      chk("frame_start", {31'd0, o_frame_start}, {31'd0, (mh == 0 && mv == 0)});
      if (mh == 0 && mv == 0) begin
        if (last_fs >= 0) chk("frame_period", 32'(cyc - last_fs), 32'(HT * VT));
        last_fs = cyc;
        frames++;
      end

      rst_now = !did_rst && frames == 2 && mh == 10 && mv == 5;
      reset   = rst_now;
      hit     = ($urandom_range(3) == 0) ? '1 : 4'($urandom);
      if (c == 0)      begin pal_we = 1'b1; pal_addr = 3'd1; pal_data = pack_rgb(2'b11, 2'b00, 2'b00); end
      else if (c == 1) begin pal_we = 1'b1; pal_addr = 3'd2; pal_data = pack_rgb(2'b00, 2'b11, 2'b00); end
      else if (c == 2) begin pal_we = 1'b1; pal_addr = 3'd4; pal_data = pack_rgb(2'b00, 2'b00, 2'b11); end
      else begin
        pal_we   = !rst_now && ($urandom_range(5) == 0);
        pal_addr = 3'($urandom);
        pal_data = 6'($urandom);
      end

      cur.de = (mh < HA) && (mv < VA);
      cur.hs = (mh >= HA + HFP) && (mh < HA + HFP + HS);
      cur.vs = (mv >= VA + VFP) && (mv < VA + VFP + VS);
      hist.push_back(cur);
      d = hist.pop_front();
      idx = NL;
      for (int k = NL - 1; k >= 0; k--) if (hit[k]) idx = k;
      e.due = cyc + 1;
      if (rst_now) begin
        e.rgb = '0; e.hs = 1'b0; e.vs = 1'b0;
      end else begin
        e.rgb = d.de ? pal_m[idx] : 6'd0;
        e.hs  = d.hs;
        e.vs  = d.vs;
      end
      sb.push_back(e);
      if (!rst_now && pal_we && pal_addr <= 3'(NL)) pal_m[pal_addr] = pal_data;

      @(posedge clk);
      cyc++;
      #1;
      if (rst_now) begin
        did_rst = 1;
        last_fs = -1;
        model_reset();
      end else begin
        mh++;
        if (mh == HT) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end
      end
    end
    reset = 1'b0; pal_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("did_reset", {31'd0, did_rst}, 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/graphics_layer_mixer.md
Name: graphics_layer_mixer

Overview:
Parametrised successor to the current VGA output stage. It owns the hsync/vsync/position timing, takes per-layer "pixel hit" flags from the game renderers, and resolves them by fixed priority into a palette colour. The raster timing, layer count, colour depth and renderer latency are all parameters. Syncs and blanking are delay-matched to the renderers' latency, and the palette is writable at run time. It sits between the game logic (obstacle/player/score/background renderers) and the VGA pins.

Parameters:
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in clocks.
- H_SYNC, 96: hsync pulse width, in clocks.
- H_BP, 48: horizontal back porch, in clocks.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_NEG, 1: 1 = syncs active-low; 0 = active-high.
- NUM_LAYERS, 4: number of layer-hit inputs (1..8). Index 0 has the highest priority.
- COLOR_BITS, 2: bits per R/G/B channel.
- LAYER_LAT, 0: clocks from o_hpos/o_vpos to the matching i_layer_hit (0..7).
- CONV, 0: low position bits dropped on o_hpos/o_vpos.

Ports:
- clk, in, 1: pixel clock.
- reset, in, 1: synchronous, active-high.
- i_layer_hit, in, NUM_LAYERS: bit k = layer k covers the pixel at o_hpos/o_vpos, delayed by LAYER_LAT.
- i_pal_we, in, 1: palette write strobe.
- i_pal_addr, in, clog2(NUM_LAYERS+1): palette entry. Entry NUM_LAYERS is the no-hit/background colour.
- i_pal_data, in, 3*COLOR_BITS: colour to write, packed {R,G,B}.
- o_hpos, out, [9:CONV]: current horizontal counter, with CONV low bits dropped.
- o_vpos, out, [9:CONV]: current vertical counter, with CONV low bits dropped.
- o_frame_start, out, 1: one-clock pulse when hpos=0 and vpos=0.
- o_hsync, out, 1: delay-aligned hsync.
- o_vsync, out, 1: delay-aligned vsync.
- o_red, out, COLOR_BITS: red channel, aligned with the syncs.
- o_green, out, COLOR_BITS: green channel, aligned with the syncs.
- o_blue, out, COLOR_BITS: blue channel, aligned with the syncs.

Behaviour:
- Timing counters:
  - hpos counts 0..H_TOTAL-1 (H_TOTAL = sum of the H_* parameters), then wraps to 0.
  - vpos increments on the hpos wrap. It wraps at V_TOTAL-1 when hpos also wraps.
  - Counters are 10 bits wide. An elaboration-time check requires H_TOTAL and V_TOTAL to be at most 1024.
- Raw raster signals:
  - display_on = (hpos < H_ACTIVE) and (vpos < V_ACTIVE).
  - hsync_raw is asserted when H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC.
  - vsync_raw is defined the same way on vpos with the V_* parameters.
  - Polarity is applied per SYNC_NEG.
- Positions: o_hpos/o_vpos are combinational from the counters. o_frame_start is combinational from the counters.
- Delay line: a LAYER_LAT-deep shift register carries {hsync_raw, vsync_raw, display_on} so they line up with i_layer_hit.
- Resolve stage (registered):
  - Winning index = lowest k with i_layer_hit[k]=1; if no bit is set, index = NUM_LAYERS.
  - Colour = palette[index] when the delayed display_on is 1, otherwise 0 on all channels. Blanking is always black; there is no debug colour.
  - Delayed hsync/vsync are registered in the same stage.
  - End-to-end latency: position to pins = LAYER_LAT+1 clocks, for colour and syncs alike.
- Palette:
  - NUM_LAYERS+1 registers written on i_pal_we. A write is visible to the resolve stage from the next clock.
  - If a write and a read of the same entry occur in the same cycle, the read returns the old value.
  - i_pal_addr > NUM_LAYERS: the write is ignored.
- Reset (synchronous):
  - hpos = vpos = 0.
  - All delay-line stages cleared to display_on=0 with syncs at their inactive level.
  - o_red/o_green/o_blue = 0; o_hsync/o_vsync inactive (1 when SYNC_NEG=1).
  - Palette: layer entries = all-ones (white); background entry = 0.
  - Reset asserted mid-frame aborts the frame. First post-reset cycle: hpos=0, vpos=0, o_frame_start=1.
- Boundary conditions:
  - Hit inputs are ignored while the delayed display_on is 0.
  - All layer bits set: layer 0 wins.
  - With LAYER_LAT=0 the delay line degenerates to wires and the only register is the resolve stage.

Decomposition:
- Shared package graphics_pkg holds:
  - VGA 640x480 timing constants.
  - COLOR_BITS default.
  - Packed colour typedef and function pack_rgb.
  - Default palette constants WHITE and BLACK.
- One sub-module, vga_timing: counters, display_on, raw syncs and frame_start. It is reusable by other display blocks.
- Priority encoder, delay line and palette stay in graphics_layer_mixer.

Test Plan:
- Reset then free-run with defaults:
  - hsync low for exactly 96 clocks per 800-clock line, starting at hpos=656.
  - vsync low for exactly 2 lines per 525-line frame, starting at vpos=490.
  - o_frame_start pulses once every 420000 clocks.
- LAYER_LAT=3, drive i_layer_hit=4'b0010 only at hpos=100, vpos=50 (delayed 3 clocks):
  - o_red/o_green/o_blue=2'b11 for exactly one clock, 4 clocks after o_hpos=100.
  - o_hsync edges are shifted by 4 clocks relative to the raw counters.
- i_layer_hit=4'b1110 with palette[1]=6'b110000 and palette[2]=6'b001100 → output 6'b110000. i_layer_hit=4'b0000 with palette[4]=6'b000011 → 6'b000011.
- Hits forced all-ones during hpos 640..799 → all channels 0 throughout the blanking interval.
- Palette writes:
  - Write palette[0]=6'b101010 while layer 0 is hit → the old value is output for that clock, then 6'b101010 from the next clock.
  - A write to addr 5 (NUM_LAYERS=4) changes nothing.
- Assert reset for 1 clock at hpos=300, vpos=200 → next cycle hpos=0, vpos=0, o_frame_start=1, colours 0, syncs inactive, palette back to defaults.
